alu_div_sequencer: RTL and testbench

// - Multicycle unsigned 32-bit divider (DIVU/REMU) for the multicycle RISC-V core.
// - Holds no adder of its own. It drives the shared combinational ALU through that
//   ALU's operand/select interface (A, B, Cin, sel in; ALUOut, Carry out) and

---
 rtl/alu_div_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_div_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// alu_div_sequencer : restoring DIVU/REMU, one step per clock via shared ALU
// Revision: 1.0
// ============================================================================
module alu_div_sequencer #(
   parameter int WIDTH    = 32,
   parameter int CNT_W    = 6,
   parameter int FAST_DBZ = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dbz,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cin,
   output logic [1:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dbz_op;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic             r_dbz;

   logic             w_accept;
   logic             w_zero_div;
   logic             w_fast_dbz;
   logic             w_last;
   logic [WIDTH-1:0] w_shift;
   logic             w_ok;
   logic [WIDTH-1:0] w_r_nxt;
   logic [WIDTH-1:0] w_q_nxt;

   assign w_accept   = (r_state != S_RUN) && start;
   assign w_zero_div = (divisor == '0);
   assign w_fast_dbz = (FAST_DBZ != 0) && w_zero_div;
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

   // A set R[31] means the 33-bit partial remainder already exceeds D.
   assign w_shift = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
   assign w_ok    = r_r[WIDTH-1] | alu_carry;
   assign w_r_nxt = w_ok ? alu_out : w_shift;
   assign w_q_nxt = {r_q[WIDTH-2:0], w_ok};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = S_IDLE;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_next_state = w_fast_dbz ? S_DONE : S_RUN;
            end
         end
         S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      ready   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      alu_a   = '0;
      alu_b   = '0;
      alu_cin = 1'b0;
      alu_sel = 2'b00;
      case (r_state)
         S_IDLE: ready = 1'b1;
         S_RUN: begin
            busy    = 1'b1;
            alu_a   = w_shift;
            alu_b   = r_d;
            alu_cin = 1'b1;
         end
         S_DONE: begin
            ready = 1'b1;
            done  = 1'b1;
         end
         default: ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d      <= '0;
         r_q      <= '0;
         r_r      <= '0;
         r_cnt    <= '0;
         r_dbz_op <= 1'b0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_dbz    <= 1'b0;
      end else if (w_accept) begin
         r_d      <= divisor;
         r_q      <= dividend;
         r_r      <= '0;
         r_cnt    <= '0;
         r_dbz_op <= w_zero_div;
         if (w_fast_dbz) begin
            r_quo <= '1;
            r_rem <= dividend;
            r_dbz <= 1'b1;
         end
      end else if (r_state == S_RUN) begin
         r_r   <= w_r_nxt;
         r_q   <= w_q_nxt;
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_quo <= w_q_nxt;
            r_rem <= w_r_nxt;
            r_dbz <= r_dbz_op;
         end
      end
   end

   assign quotient  = r_quo;
   assign remainder = r_rem;
   assign dbz       = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_div_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_alu_div_sequencer : directed bench, index 0 = FAST_DBZ 0, index 1 = FAST_DBZ 1
// Revision: 1.0
// ============================================================================
module tb_alu_div_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;

   logic        d_ready [2];
   logic        d_busy  [2];
   logic        d_done  [2];
   logic [31:0] d_quo   [2];
   logic [31:0] d_rem   [2];
   logic        d_dbz   [2];
   logic [31:0] d_alu_a [2];
   logic [31:0] d_alu_b [2];
   logic        d_cin   [2];
   logic [1:0]  d_sel   [2];
   logic [31:0] d_aout  [2];
   logic        d_acar  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Shared-ALU stand-in: add, or subtract via inverted B plus carry-in.
   function automatic logic [32:0] alu(input logic [31:0] a, input logic [31:0] b, input logic cin);
      return {1'b0, a} + {1'b0, (cin ? ~b : b)} + {32'd0, cin};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign {d_acar[g], d_aout[g]} = alu(d_alu_a[g], d_alu_b[g], d_cin[g]);
      alu_div_sequencer #(.WIDTH(32), .CNT_W(6), .FAST_DBZ(g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start),
         .dividend  (dividend),
         .divisor   (divisor),
         .ready     (d_ready[g]),
         .busy      (d_busy[g]),
         .done      (d_done[g]),
         .quotient  (d_quo[g]),
         .remainder (d_rem[g]),
         .dbz       (d_dbz[g]),
         .alu_a     (d_alu_a[g]),
         .alu_b     (d_alu_b[g]),
         .alu_cin   (d_cin[g]),
         .alu_sel   (d_sel[g]),
         .alu_out   (d_aout[g]),
         .alu_carry (d_acar[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 running (m_left edges to go), 2 done.
   int          m_phase [2];
   int          m_left  [2];
   logic [31:0] m_q     [2];
   logic [31:0] m_r     [2];
   logic        m_dbz   [2];
   logic [31:0] m_dvs   [2];
   logic [31:0] p_q     [2];
   logic [31:0] p_r     [2];
   logic        p_dbz   [2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_phase[k] = 0; m_left[k] = 0; m_q[k] = 0; m_r[k] = 0;
            m_dbz[k] = 1'b0; m_dvs[k] = 0;
         end else if (m_phase[k] == 1) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
               m_phase[k] = 2;
               m_q[k] = p_q[k]; m_r[k] = p_r[k]; m_dbz[k] = p_dbz[k];
            end
         end else if (start) begin
            m_dvs[k] = divisor;
            if (divisor == 0) begin
               p_q[k] = 32'hFFFF_FFFF; p_r[k] = dividend; p_dbz[k] = 1'b1;
            end else begin
               p_q[k] = dividend / divisor; p_r[k] = dividend % divisor; p_dbz[k] = 1'b0;
            end
            if (k == 1 && divisor == 0) begin
               m_phase[k] = 2;
               m_q[k] = p_q[k]; m_r[k] = p_r[k]; m_dbz[k] = p_dbz[k];
            end else begin
               m_phase[k] = 1;
               m_left[k]  = 32;
            end
         end else begin
            m_phase[k] = 0;
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("i%0d_ready", k), 32'(d_ready[k]), 32'(m_phase[k] != 1));
         chk($sformatf("i%0d_busy", k),  32'(d_busy[k]),  32'(m_phase[k] == 1));
         chk($sformatf("i%0d_done", k),  32'(d_done[k]),  32'(m_phase[k] == 2));
         chk($sformatf("i%0d_quotient", k),  d_quo[k], m_q[k]);
         chk($sformatf("i%0d_remainder", k), d_rem[k], m_r[k]);
         chk($sformatf("i%0d_dbz", k),   32'(d_dbz[k]), 32'(m_dbz[k]));
         chk($sformatf("i%0d_alu_cin", k), 32'(d_cin[k]), 32'(m_phase[k] == 1));
         chk($sformatf("i%0d_alu_sel", k), 32'(d_sel[k]), 32'd0);
         chk($sformatf("i%0d_alu_b", k), d_alu_b[k], (m_phase[k] == 1) ? m_dvs[k] : 32'd0);
         if (m_phase[k] != 1) chk($sformatf("i%0d_alu_a_idle", k), d_alu_a[k], 32'd0);
      end
   end

   // One operation; index i counts edges after the accepting edge.
   task automatic op(input logic [31:0] dvd, input logic [31:0] dvs,
                     input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                     input int lat0, input int lat1, input bit issue,
                     input int pulse_at, input logic [31:0] pdvd, input logic [31:0] pdvs,
                     input int reset_at);
      int seen [2];
      seen[0] = -1;
      seen[1] = -1;
      if (issue) begin
         @(posedge clk); #1;
         start = 1'b1; dividend = dvd; divisor = dvs;
      end
      @(posedge clk); #1;
      start = 1'b0; dividend = $urandom; divisor = $urandom;
      for (int i = 0; i <= 40; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst_n = 1'b1;
         end
         for (int k = 0; k < 2; k++) begin
            if (d_done[k] && seen[k] < 0) begin
               seen[k] = i;
               chk($sformatf("op%0d_i%0d_quotient", dvd, k), d_quo[k], eq);
               chk($sformatf("op%0d_i%0d_remainder", dvd, k), d_rem[k], er);
               chk($sformatf("op%0d_i%0d_dbz", dvd, k), 32'(d_dbz[k]), 32'(edbz));
            end
         end
         if (i == pulse_at) begin
            start = 1'b1; dividend = pdvd; divisor = pdvs;
         end
         if (i == reset_at) begin
            rst_n = 1'b0;
            #1;
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("rst_i%0d_ready", k), 32'(d_ready[k]), 32'd1);
               chk($sformatf("rst_i%0d_quotient", k), d_quo[k], 32'd0);
            end
         end
         if (seen[0] >= 0 && seen[1] >= 0 && i >= pulse_at) break;
      end
      if (reset_at >= 0) begin
         chk("no_done_after_reset_i0", 32'(seen[0]), 32'hFFFF_FFFF);
         chk("no_done_after_reset_i1", 32'(seen[1]), 32'hFFFF_FFFF);
      end else begin
         chk($sformatf("op%0d_latency_i0", dvd), 32'(seen[0]), 32'(lat0));
         chk($sformatf("op%0d_latency_i1", dvd), 32'(seen[1]), 32'(lat1));
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset_i%0d_ready", k), 32'(d_ready[k]), 32'd1);
         chk($sformatf("reset_i%0d_busy", k),  32'(d_busy[k]),  32'd0);
         chk($sformatf("reset_i%0d_done", k),  32'(d_done[k]),  32'd0);
         chk($sformatf("reset_i%0d_quotient", k), d_quo[k], 32'd0);
      end
      rst_n = 1'b1;

      op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 32, 1'b1, -1, 0, 0, -1);
      op(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 32, 32, 1'b1, -1, 0, 0, -1);
      op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, 32, 1'b1, -1, 0, 0, -1);
      op(32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 32, 32, 1'b1, -1, 0, 0, -1);
      op(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 32, 0, 1'b1, -1, 0, 0, -1);
      // start during RUN must be ignored
      op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 32, 32, 1'b1, 10, 32'd77, 32'd5, -1);
      // back-to-back: second start held high in the DONE cycle
      op(32'd200, 32'd6, 32'd33, 32'd2, 1'b0, 32, 32, 1'b1, 32, 32'd50, 32'd7, -1);
      op(32'd50, 32'd7, 32'd7, 32'd1, 1'b0, 32, 32, 1'b0, -1, 0, 0, -1);
      // reset mid-RUN, then a clean operation
      op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 32, 1'b1, -1, 0, 0, 15);
      op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 32, 1'b1, -1, 0, 0, -1);
      for (int n = 0; n < 4; n++) begin
         a = $urandom;
         b = $urandom >> (n * 8);
         if (b == 0) b = 32'd3;
         op(a, b, a / b, a % b, 1'b0, 32, 32, 1'b1, -1, 0, 0, -1);
      end

      repeat (2) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
